// File: rtl/nf10_axis_pkg.sv
// Shared definitions for the NetFPGA-10G AXI-Stream receive path:
// tuser metadata field offsets, byte-enable popcount and the ingress state type.
package nf10_axis_pkg;

    localparam int LEN_LO = 0;
    localparam int LEN_HI = 15;
    localparam int SRC_LO = 16;
    localparam int DST_LO = 24;

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        DROP
    } rx_state_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/nf10_rx_stamper_fifo.sv
// Synchronous FIFO whose read side only sees committed writes; a rewind
// discards everything written since the last commit.
module nf10_rx_stamper_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  commit,
    input  logic                  rewind,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   used
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr, cmt_ptr, rd_ptr, wr_ptr_nxt;

    assign wr_ptr_nxt = wr_ptr + {{DEPTH_LOG2{1'b0}}, wr_en};

    // Commit publishes the pointer including any beat written this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            cmt_ptr <= '0;
            rd_ptr  <= '0;
        end else begin
            if (rewind) begin
                wr_ptr <= cmt_ptr;
            end else begin
                wr_ptr <= wr_ptr_nxt;
            end
            if (commit) begin
                cmt_ptr <= wr_ptr_nxt;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

    // Occupancy counts uncommitted entries too, so the writer sees true fullness.
    assign used    = wr_ptr - rd_ptr;
    assign empty   = (cmt_ptr == rd_ptr);
    assign rd_data = mem[rd_ptr[DEPTH_LOG2-1:0]];

endmodule

// File: rtl/nf10_10g_rx_stamper.sv
// Store-and-forward 10G receive stage: buffers whole packets, drops those that
// do not fit, and stamps length/source port into the first egress tuser beat.
module nf10_10g_rx_stamper
    import nf10_axis_pkg::*;
#(
    parameter int         C_DATA_WIDTH      = 64,
    parameter int         C_TUSER_WIDTH     = 128,
    parameter logic [7:0] C_SRC_PORT        = 8'h01,
    parameter int         C_DATA_DEPTH_LOG2 = 9,
    parameter int         C_META_DEPTH_LOG2 = 4
) (
    input  logic                       axi_aclk,
    input  logic                       axi_resetn,
    input  logic [C_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,
    output logic [C_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [31:0]                drop_count
);

    localparam int STRB_W = C_DATA_WIDTH / 8;
    localparam int DATA_W = C_DATA_WIDTH + STRB_W + 1;
    localparam int HI_W   = C_TUSER_WIDTH - 32;
    localparam int META_W = HI_W + 16;
    localparam int WORD_W = C_TUSER_WIDTH + DATA_W;

    rx_state_t                   state;
    logic [15:0]                 byte_cnt, beat_bytes, cnt_next;
    logic [16:0]                 cnt_sum;
    logic [HI_W-1:0]             tuser_hi, pkt_hi;
    logic                        meta_push;
    logic [META_W-1:0]           meta_wdata, meta_rdata;
    logic [1:0]                  meta_inflight;
    logic [C_META_DEPTH_LOG2:0]  meta_used;
    logic [C_META_DEPTH_LOG2+1:0] meta_load;
    logic                        meta_full, meta_empty;
    logic [C_DATA_DEPTH_LOG2:0]  data_used;
    logic                        data_full, data_empty;
    logic                        beat_hs, in_pkt_beat, beat_drop, data_wr, data_commit;
    logic                        tuser_lo_unused;

    logic [DATA_W-1:0]           data_rdata;
    logic [C_TUSER_WIDTH-1:0]    src_tuser;
    logic [WORD_W-1:0]           src_word, skid_word;
    logic                        src_valid, src_load, src_last, skid_valid, rd_first;

    assign tuser_lo_unused = ^s_axis_tuser[31:0];

    always_comb begin
        beat_bytes = 16'd0;
        for (int i = 0; i < STRB_W / 8; i++) begin
            beat_bytes = beat_bytes + {12'd0, popcount8(s_axis_tstrb[i*8 +: 8])};
        end
    end

    assign cnt_sum  = {1'b0, (state == ACCEPT) ? byte_cnt : 16'd0} + {1'b0, beat_bytes};
    assign cnt_next = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    assign pkt_hi   = (state == ACCEPT) ? tuser_hi : s_axis_tuser[C_TUSER_WIDTH-1:32];

    // Meta occupancy includes the pending push and entries still in the output stage.
    assign meta_load = {1'b0, meta_used}
                     + {{(C_META_DEPTH_LOG2+1){1'b0}}, meta_push}
                     + {{C_META_DEPTH_LOG2{1'b0}}, meta_inflight};
    assign meta_full = meta_load[C_META_DEPTH_LOG2+1] | meta_load[C_META_DEPTH_LOG2];
    assign data_full = data_used[C_DATA_DEPTH_LOG2];

    assign beat_hs     = s_axis_tvalid && s_axis_tready;
    assign in_pkt_beat = beat_hs && (state != DROP);
    assign beat_drop   = in_pkt_beat && (data_full || (s_axis_tlast && meta_full));
    assign data_wr     = in_pkt_beat && !beat_drop;
    assign data_commit = data_wr && s_axis_tlast;

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state         <= IDLE;
            s_axis_tready <= 1'b0;
            byte_cnt      <= '0;
            tuser_hi      <= '0;
            meta_push     <= 1'b0;
            meta_wdata    <= '0;
            drop_count    <= '0;
        end else begin
            s_axis_tready <= 1'b1;
            meta_push     <= data_commit;
            if (data_commit) begin
                meta_wdata <= {pkt_hi, cnt_next};
            end
            if (data_wr) begin
                byte_cnt <= cnt_next;
            end
            if (beat_hs && state == IDLE) begin
                tuser_hi <= s_axis_tuser[C_TUSER_WIDTH-1:32];
            end
            if (beat_drop && drop_count != 32'hFFFF_FFFF) begin
                drop_count <= drop_count + 32'd1;
            end
            unique case (state)
                IDLE, ACCEPT: begin
                    if (beat_hs) begin
                        if (s_axis_tlast) begin
                            state <= IDLE;
                        end else if (beat_drop) begin
                            state <= DROP;
                        end else begin
                            state <= ACCEPT;
                        end
                    end
                end
                DROP: begin
                    if (beat_hs && s_axis_tlast) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    nf10_rx_stamper_fifo #(
        .WIDTH      (DATA_W),
        .DEPTH_LOG2 (C_DATA_DEPTH_LOG2)
    ) u_data_fifo (
        .clk     (axi_aclk),
        .rst_n   (axi_resetn),
        .wr_en   (data_wr),
        .wr_data ({s_axis_tlast, s_axis_tstrb, s_axis_tdata}),
        .commit  (data_commit),
        .rewind  (beat_drop),
        .rd_en   (src_load),
        .rd_data (data_rdata),
        .empty   (data_empty),
        .used    (data_used)
    );

    nf10_rx_stamper_fifo #(
        .WIDTH      (META_W),
        .DEPTH_LOG2 (C_META_DEPTH_LOG2)
    ) u_meta_fifo (
        .clk     (axi_aclk),
        .rst_n   (axi_resetn),
        .wr_en   (meta_push),
        .wr_data (meta_wdata),
        .commit  (1'b1),
        .rewind  (1'b0),
        .rd_en   (src_load && src_last),
        .rd_data (meta_rdata),
        .empty   (meta_empty),
        .used    (meta_used)
    );

    always_comb begin
        src_tuser = '0;
        if (rd_first) begin
            src_tuser[LEN_HI:LEN_LO]          = meta_rdata[15:0];
            src_tuser[DST_LO-1:SRC_LO]        = C_SRC_PORT;
            src_tuser[C_TUSER_WIDTH-1:32]     = meta_rdata[META_W-1:16];
        end
    end

    assign src_last  = data_rdata[DATA_W-1];
    assign src_word  = {src_tuser, data_rdata};
    assign src_valid = !meta_empty && !data_empty;
    assign src_load  = src_valid && !skid_valid;

    // Output register plus one skid entry; upstream pull is gated only by the skid.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            m_axis_tvalid <= 1'b0;
            {m_axis_tuser, m_axis_tlast, m_axis_tstrb, m_axis_tdata} <= '0;
            skid_valid    <= 1'b0;
            skid_word     <= '0;
            rd_first      <= 1'b1;
            meta_inflight <= 2'd0;
        end else begin
            if (src_load) begin
                rd_first <= src_last;
            end
            case ({src_load && src_last, m_axis_tvalid && m_axis_tready && m_axis_tlast})
                2'b10:   meta_inflight <= meta_inflight + 2'd1;
                2'b01:   meta_inflight <= meta_inflight - 2'd1;
                default: meta_inflight <= meta_inflight;
            endcase
            if (!m_axis_tvalid || m_axis_tready) begin
                if (skid_valid) begin
                    {m_axis_tuser, m_axis_tlast, m_axis_tstrb, m_axis_tdata} <= skid_word;
                    m_axis_tvalid <= 1'b1;
                    skid_valid    <= 1'b0;
                end else if (src_load) begin
                    {m_axis_tuser, m_axis_tlast, m_axis_tstrb, m_axis_tdata} <= src_word;
                    m_axis_tvalid <= 1'b1;
                end else begin
                    m_axis_tvalid <= 1'b0;
                end
            end else if (src_load) begin
                skid_word  <= src_word;
                skid_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nf10_10g_rx_stamper.sv
// Directed bench for nf10_10g_rx_stamper: scoreboarded egress, drop cases,
// output stability under back-pressure and mid-packet reset.
module tb_nf10_10g_rx_stamper;

    logic         axi_aclk = 1'b0;
    logic         axi_resetn = 1'b0;
    logic [63:0]  s_axis_tdata = '0;
    logic [7:0]   s_axis_tstrb = '0;
    logic [127:0] s_axis_tuser = '0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tready;
    logic         s_axis_tlast = 1'b0;
    logic [63:0]  m_axis_tdata;
    logic [7:0]   m_axis_tstrb;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b1;
    logic         m_axis_tlast;
    logic [31:0]  drop_count;

    typedef struct {
        int id;
        int nbytes;
    } pkt_t;

    pkt_t exp_q[$];
    int   check_cnt = 0;
    int   err_cnt = 0;
    bit   rand_ready_en = 1'b0;

    nf10_10g_rx_stamper dut (
        .axi_aclk      (axi_aclk),
        .axi_resetn    (axi_resetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .drop_count    (drop_count)
    );

    always #5 axi_aclk = ~axi_aclk;

    task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
        check_cnt++;
        if (actual !== expected) begin
            err_cnt++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [63:0] beatData(input int id, input int b);
        logic [31:0] i32, b32;
        i32 = id;
        b32 = b;
        return {i32[15:0], b32[15:0], ~i32[15:0] ^ 16'h3C3C, b32[15:0] ^ 16'hA5A5};
    endfunction

    function automatic logic [95:0] tuserHi(input int id);
        logic [31:0] i32;
        i32 = id;
        return {i32, ~i32, 32'h0BAD_F00D ^ i32};
    endfunction

    function automatic logic [7:0] lastStrb(input int nbytes);
        int rem;
        rem = nbytes % 8;
        return (rem == 0) ? 8'hFF : 8'((1 << rem) - 1);
    endfunction

    // Drives one packet back-to-back; returns at posedge+1 after the tlast edge.
    task automatic applyStimulus(input int id, input int nbytes, input bit expect_ok);
        int   nb;
        pkt_t p;
        nb = (nbytes + 7) / 8;
        if (expect_ok) begin
            p.id = id;
            p.nbytes = nbytes;
            exp_q.push_back(p);
        end
        for (int b = 0; b < nb; b++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = beatData(id, b);
            s_axis_tstrb  = (b == nb - 1) ? lastStrb(nbytes) : 8'hFF;
            s_axis_tlast  = (b == nb - 1);
            s_axis_tuser  = (b == 0) ? {tuserHi(id), 32'hDEAD_BEEF} : {$urandom, $urandom, $urandom, $urandom};
            @(posedge axi_aclk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic waitQueue(input string tag, input int limit);
        int n;
        n = 0;
        while (exp_q.size() > limit && n < 5000) begin
            @(posedge axi_aclk);
            #1;
            n++;
        end
        checkOutput(tag, exp_q.size() > limit, 0);
    endtask

    always begin
        @(posedge axi_aclk);
        #1;
        if (rand_ready_en) begin
            m_axis_tready = ($urandom_range(0, 3) != 0);
        end
    end

    // Egress monitor: scoreboard every handshaken beat and require stalled outputs to hold.
    logic [201:0] cur_word, prev_word;
    bit           stall_prev = 1'b0;
    int           mon_beat = 0;

    always @(negedge axi_aclk) begin
        pkt_t        e;
        int          nb;
        logic [15:0] len16;
        if (!axi_resetn) begin
            stall_prev = 1'b0;
            mon_beat   = 0;
        end else begin
            cur_word = {m_axis_tvalid, m_axis_tlast, m_axis_tstrb, m_axis_tuser, m_axis_tdata};
            if (stall_prev) begin
                checkOutput("stall_hold", cur_word, prev_word);
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            prev_word  = cur_word;
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_beat", exp_q.size(), 1);
                end else begin
                    e     = exp_q[0];
                    nb    = (e.nbytes + 7) / 8;
                    len16 = 16'(e.nbytes);
                    checkOutput("tdata", m_axis_tdata, beatData(e.id, mon_beat));
                    checkOutput("tstrb", m_axis_tstrb, (mon_beat == nb - 1) ? lastStrb(e.nbytes) : 8'hFF);
                    checkOutput("tlast", m_axis_tlast, mon_beat == nb - 1);
                    checkOutput("tuser", m_axis_tuser,
                                (mon_beat == 0) ? {tuserHi(e.id), 8'h00, 8'h01, len16} : 128'h0);
                    if (mon_beat == nb - 1) begin
                        void'(exp_q.pop_front());
                        mon_beat = 0;
                    end else begin
                        mon_beat++;
                    end
                end
            end
        end
    end

    initial begin
        int cnt;
        int nbytes;

        // Reset state
        #1;
        checkOutput("rst_s_tready", s_axis_tready, 0);
        checkOutput("rst_m_tvalid", m_axis_tvalid, 0);
        checkOutput("rst_m_tdata", m_axis_tdata, 0);
        checkOutput("rst_m_tuser", m_axis_tuser, 0);
        checkOutput("rst_drop_count", drop_count, 0);
        #21 axi_resetn = 1'b1;
        #2 checkOutput("tready_before_edge", s_axis_tready, 0);
        @(posedge axi_aclk);
        #1;
        checkOutput("tready_after_edge", s_axis_tready, 1);

        // 64-byte packet and first-beat latency
        applyStimulus(1, 64, 1);
        @(negedge axi_aclk);
        checkOutput("lat_edge_n", m_axis_tvalid, 0);
        @(negedge axi_aclk);
        checkOutput("lat_edge_n1", m_axis_tvalid, 0);
        @(negedge axi_aclk);
        checkOutput("lat_edge_n2", m_axis_tvalid, 1);
        checkOutput("lat_tuser_lo", m_axis_tuser[31:0], 32'h0001_0040);
        @(posedge axi_aclk);
        #1;
        waitQueue("drain_64b", 0);

        // Partial last beat and a single-beat packet
        applyStimulus(2, 61, 1);
        applyStimulus(3, 5, 1);
        waitQueue("drain_short", 0);

        // Sixteen packets fill the meta FIFO; the next two are dropped whole
        m_axis_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(10 + i, 64, 1);
        end
        applyStimulus(26, 64, 0);
        applyStimulus(27, 5, 0);
        checkOutput("drops_meta_full", drop_count, 2);
        checkOutput("stalled_valid", m_axis_tvalid, 1);
        m_axis_tready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 128; i++) begin
            @(negedge axi_aclk);
            if (m_axis_tvalid) cnt++;
        end
        checkOutput("no_gap_beats", cnt, 128);
        @(posedge axi_aclk);
        #1;
        waitQueue("drain_burst", 0);

        // Oversized packet dropped, following packet intact
        applyStimulus(30, 4800, 0);
        applyStimulus(31, 64, 1);
        checkOutput("drops_oversize", drop_count, 3);
        waitQueue("drain_oversize", 0);

        // Random back-pressure over mixed packet sizes
        rand_ready_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            nbytes = $urandom_range(60, 1514);
            waitQueue("rand_pace", 1);
            applyStimulus(100 + i, nbytes, 1);
        end
        waitQueue("drain_random", 0);
        rand_ready_en = 1'b0;
        m_axis_tready = 1'b1;
        checkOutput("drops_after_random", drop_count, 3);

        // Reset in the middle of a packet with a stalled packet on the output
        m_axis_tready = 1'b0;
        applyStimulus(500, 64, 0);
        repeat (3) begin
            @(posedge axi_aclk);
            #1;
        end
        checkOutput("pre_reset_valid", m_axis_tvalid, 1);
        for (int b = 0; b < 4; b++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = beatData(501, b);
            s_axis_tstrb  = 8'hFF;
            s_axis_tuser  = {tuserHi(501), 32'h0};
            @(posedge axi_aclk);
            #1;
        end
        #1 axi_resetn = 1'b0;
        s_axis_tvalid = 1'b0;
        #1;
        checkOutput("mid_rst_m_tvalid", m_axis_tvalid, 0);
        checkOutput("mid_rst_m_tdata", m_axis_tdata, 0);
        checkOutput("mid_rst_m_tstrb", m_axis_tstrb, 0);
        checkOutput("mid_rst_m_tuser", m_axis_tuser, 0);
        checkOutput("mid_rst_m_tlast", m_axis_tlast, 0);
        checkOutput("mid_rst_s_tready", s_axis_tready, 0);
        checkOutput("mid_rst_drops", drop_count, 0);
        @(negedge axi_aclk);
        #1 axi_resetn = 1'b1;
        checkOutput("rel_tready_before_edge", s_axis_tready, 0);
        @(posedge axi_aclk);
        #1;
        checkOutput("rel_tready_after_edge", s_axis_tready, 1);
        m_axis_tready = 1'b1;
        repeat (4) @(negedge axi_aclk);
        checkOutput("no_stale_output", m_axis_tvalid, 0);
        @(posedge axi_aclk);
        #1;
        applyStimulus(502, 100, 1);
        waitQueue("drain_after_reset", 0);
        checkOutput("drops_after_reset", drop_count, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, check_cnt);
        $finish;
    end

endmodule
